// File: rtl/mantissa_shift_sequencer_pkg.sv
// Shared floating-point adder definitions: sequencer state encoding, shift-register
// command codes and mantissa width.
package fp_adder_pkg;

  localparam int unsigned MANT_W = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } seq_state_e;

  typedef logic [1:0] sr_cmd_t;

  localparam sr_cmd_t SR_HOLD  = 2'b00;
  localparam sr_cmd_t SR_RIGHT = 2'b01;
  localparam sr_cmd_t SR_LEFT  = 2'b10;
  localparam sr_cmd_t SR_LOAD  = 2'b11;

endpackage

// File: rtl/mantissa_shift_sequencer_if.sv
// Request/result bundle between the exponent stages (master) and the mantissa
// shift sequencer (slave).
interface mantissa_shift_sequencer_if
  import fp_adder_pkg::*;
#(
  parameter int unsigned WIDTH = MANT_W,
  parameter int unsigned CNT_W = 5,
  parameter int unsigned AMT_W = 8
);

  logic             Start;
  logic             Mode;
  logic [WIDTH-1:0] M_in;
  logic [AMT_W-1:0] Shift_amt;
  logic [WIDTH-1:0] M_out;
  logic [CNT_W-1:0] Count;
  logic             Sticky;
  logic             Zero;
  logic             Busy;
  logic             Done;

  modport master (
    output Start, Mode, M_in, Shift_amt,
    input  M_out, Count, Sticky, Zero, Busy, Done
  );

  modport slave (
    input  Start, Mode, M_in, Shift_amt,
    output M_out, Count, Sticky, Zero, Busy, Done
  );

endinterface

// File: rtl/mantissa_shift_sequencer_sreg.sv
// 24-bit PIPO bidirectional shift register: hold, shift right, shift left or
// parallel load, selected by S.
module PIPO_bidirectional_shift_register
  import fp_adder_pkg::*;
#(
  parameter int unsigned WIDTH = MANT_W
) (
  input  logic             Clk,
  input  logic             Clear,
  input  sr_cmd_t          S,
  input  logic [WIDTH-1:0] I,
  output logic [WIDTH-1:0] A
);

  logic [WIDTH-1:0] r_a;

  always_ff @(posedge Clk) begin
    if (Clear) begin
      r_a <= '0;
    end else begin
      unique case (S)
        SR_HOLD:  r_a <= r_a;
        SR_RIGHT: r_a <= {1'b0, r_a[WIDTH-1:1]};
        SR_LEFT:  r_a <= {r_a[WIDTH-2:0], 1'b0};
        default:  r_a <= I;
      endcase
    end
  end

  assign A = r_a;

endmodule

// File: rtl/mantissa_shift_sequencer.sv
// Mantissa shift sequencer: loads an operand into the shift register, then either
// aligns (right shift with sticky) or normalizes (left shift until MSB set).
module mantissa_shift_sequencer
  import fp_adder_pkg::*;
#(
  parameter int unsigned WIDTH = MANT_W,
  parameter int unsigned CNT_W = 5,
  parameter int unsigned AMT_W = 8
) (
  input logic                       Clk,
  input logic                       Clear,
  mantissa_shift_sequencer_if.slave bus
);

  localparam logic [AMT_W-1:0] AmtWidth = AMT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CntWidth = CNT_W'(WIDTH);

  seq_state_e       r_state, w_state_next;
  logic             r_mode;
  logic [WIDTH-1:0] r_m_in;
  logic [CNT_W-1:0] r_target, w_target;
  logic [CNT_W-1:0] r_count, w_count_next, w_count_inc;
  logic             r_sticky, w_sticky_next;
  logic             r_zero, w_zero_next;
  sr_cmd_t          w_s;
  logic [WIDTH-1:0] w_a;

  // Oversized requests saturate so every bit ends up in the sticky.
  assign w_target    = (bus.Shift_amt >= AmtWidth) ? CntWidth : bus.Shift_amt[CNT_W-1:0];
  assign w_count_inc = r_count + CNT_W'(1);

  always_comb begin
    w_state_next  = r_state;
    w_s           = SR_HOLD;
    w_count_next  = r_count;
    w_sticky_next = r_sticky;
    w_zero_next   = r_zero;
    unique case (r_state)
      IDLE: begin
        if (bus.Start) w_state_next = LOAD;
      end
      LOAD: begin
        w_s           = SR_LOAD;
        w_count_next  = '0;
        w_sticky_next = 1'b0;
        w_zero_next   = r_mode && (r_m_in == '0);
        if ((!r_mode && (r_target == '0)) ||
            (r_mode && (r_m_in[WIDTH-1] || (r_m_in == '0)))) begin
          w_state_next = DONE;
        end else begin
          w_state_next = SHIFT;
        end
      end
      SHIFT: begin
        w_count_next = w_count_inc;
        if (!r_mode) begin
          w_s           = SR_RIGHT;
          w_sticky_next = r_sticky | w_a[0];
          if (w_count_inc == r_target) w_state_next = DONE;
        end else begin
          // The bit below the MSB becomes the MSB after this shift.
          w_s = SR_LEFT;
          if (w_a[WIDTH-2]) w_state_next = DONE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Clear) begin
      r_state  <= IDLE;
      r_count  <= '0;
      r_sticky <= 1'b0;
      r_zero   <= 1'b0;
      r_mode   <= 1'b0;
      r_m_in   <= '0;
      r_target <= '0;
    end else begin
      r_state  <= w_state_next;
      r_count  <= w_count_next;
      r_sticky <= w_sticky_next;
      r_zero   <= w_zero_next;
      if ((r_state == IDLE) && bus.Start) begin
        r_mode   <= bus.Mode;
        r_m_in   <= bus.M_in;
        r_target <= w_target;
      end
    end
  end

  PIPO_bidirectional_shift_register #(
    .WIDTH (WIDTH)
  ) u_sreg (
    .Clk   (Clk),
    .Clear (Clear),
    .S     (w_s),
    .I     (r_m_in),
    .A     (w_a)
  );

  assign bus.M_out  = w_a;
  assign bus.Count  = r_count;
  assign bus.Sticky = r_sticky;
  assign bus.Zero   = r_zero;
  assign bus.Busy   = (r_state == LOAD) || (r_state == SHIFT);
  assign bus.Done   = (r_state == DONE);

endmodule
